// File: rtl/stack_op_sequencer.sv
// Operation sequencer for the operand stack: issues push/pop/tos strobes and evaluates ops.
// Optional depth checking (underflow/overflow rejection with err) is enabled by STK_DEPTH_CHECK_EN.
module stack_op_sequencer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 32,
    parameter int DW    = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [2:0]       op_code,
    input  logic [WIDTH-1:0] op_imm,
    output logic [WIDTH-1:0] stk_din,
    output logic             stk_push,
    output logic             stk_pop,
    output logic             stk_tos,
    input  logic [WIDTH-1:0] stk_res,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             err
);

    typedef enum logic [2:0] {
        S_IDLE, S_POP1, S_POP2, S_CAP2, S_EXEC, S_PUSH, S_DONE
    } state_t;

    typedef enum logic [2:0] {
        OP_NOP  = 3'b000, OP_PUSH = 3'b001, OP_POP = 3'b010, OP_ADD = 3'b011,
        OP_SUB  = 3'b100, OP_AND  = 3'b101, OP_NOT = 3'b110, OP_TOS = 3'b111
    } op_t;

    if (DEPTH >= (1 << DW)) begin : g_dw_check
        $error("DW too narrow to hold DEPTH");
    end

    state_t           state_q;
    op_t              op_q;
    logic [WIDTH-1:0] t_q, n_q, din_q, result_q;
    logic             push_q, pop_q, tos_q, done_q, err_q;
    logic [WIDTH-1:0] r_d;
    logic             binary_q, binary_in, reject;

    assign binary_q  = (op_q == OP_ADD) || (op_q == OP_SUB) || (op_q == OP_AND);
    assign binary_in = (op_code == OP_ADD) || (op_code == OP_SUB) || (op_code == OP_AND);

`ifdef STK_DEPTH_CHECK_EN
    logic [DW-1:0] depth_q;

    // Counter follows the strobes one cycle late; every accept is at least a cycle after the last strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            depth_q <= '0;
        end else if (push_q) begin
            depth_q <= depth_q + 1'b1;
        end else if (pop_q) begin
            depth_q <= depth_q - 1'b1;
        end
    end

    always_comb begin
        reject = 1'b0;
        if ((op_code == OP_POP || op_code == OP_TOS || op_code == OP_NOT) && depth_q == '0)
            reject = 1'b1;
        if (binary_in && depth_q < DW'(2))
            reject = 1'b1;
        if (op_code == OP_PUSH && depth_q == DW'(DEPTH))
            reject = 1'b1;
    end
`else
    assign reject = 1'b0;
`endif

    always_comb begin
        r_d = t_q;
        case (op_q)
            OP_ADD:  r_d = n_q + t_q;
            OP_SUB:  r_d = n_q - t_q;
            OP_AND:  r_d = n_q & t_q;
            OP_NOT:  r_d = ~t_q;
            default: r_d = t_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            op_q     <= OP_NOP;
            t_q      <= '0;
            n_q      <= '0;
            din_q    <= '0;
            result_q <= '0;
            push_q   <= 1'b0;
            pop_q    <= 1'b0;
            tos_q    <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            push_q <= 1'b0;
            pop_q  <= 1'b0;
            tos_q  <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (op_valid) begin
                        op_q <= op_t'(op_code);
                        if (reject) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                        end else begin
                            case (op_t'(op_code))
                                OP_NOP: begin
                                    state_q <= S_DONE;
                                    done_q  <= 1'b1;
                                end
                                OP_PUSH: begin
                                    state_q <= S_PUSH;
                                    push_q  <= 1'b1;
                                    din_q   <= op_imm;
                                end
                                OP_TOS: begin
                                    state_q <= S_POP1;
                                    tos_q   <= 1'b1;
                                end
                                default: begin
                                    state_q <= S_POP1;
                                    pop_q   <= 1'b1;
                                end
                            endcase
                        end
                    end
                end
                S_POP1: begin
                    if (binary_q) begin
                        state_q <= S_POP2;
                        pop_q   <= 1'b1;
                    end else begin
                        state_q <= S_CAP2;
                    end
                end
                S_POP2: begin
                    t_q     <= stk_res;
                    state_q <= S_CAP2;
                end
                S_CAP2: begin
                    if (binary_q) n_q <= stk_res;
                    else          t_q <= stk_res;
                    state_q <= S_EXEC;
                end
                S_EXEC: begin
                    if (op_q == OP_POP || op_q == OP_TOS) begin
                        state_q  <= S_DONE;
                        done_q   <= 1'b1;
                        result_q <= r_d;
                    end else begin
                        state_q <= S_PUSH;
                        push_q  <= 1'b1;
                        din_q   <= r_d;
                    end
                end
                S_PUSH: begin
                    state_q  <= S_DONE;
                    done_q   <= 1'b1;
                    result_q <= din_q;
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign op_ready = (state_q == S_IDLE);
    assign stk_din  = din_q;
    assign stk_push = push_q;
    assign stk_pop  = pop_q;
    assign stk_tos  = tos_q;
    assign done     = done_q;
    assign result   = result_q;
    assign err      = err_q;

endmodule

// File: tb/tb_stack_op_sequencer.sv
// Directed bench for stack_op_sequencer with a behavioural 32-entry stack attached.
// Define STK_DEPTH_CHECK_EN to also exercise the depth-check rejections.
module tb_stack_op_sequencer;

    localparam logic [2:0] NOP = 3'b000, PUSH = 3'b001, POP = 3'b010, ADD = 3'b011;
    localparam logic [2:0] SUB = 3'b100, AND = 3'b101, NOT = 3'b110, TOS = 3'b111;

    logic       clk = 1'b0;
    logic       rst;
    logic       op_valid;
    logic       op_ready;
    logic [2:0] op_code;
    logic [7:0] op_imm;
    logic [7:0] stk_din;
    logic       stk_push, stk_pop, stk_tos;
    logic [7:0] stk_res;
    logic       done;
    logic [7:0] result;
    logic       err;

    int n_checks = 0;
    int n_errs   = 0;

    stack_op_sequencer #(.WIDTH(8), .DEPTH(32), .DW(6)) dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready),
        .op_code(op_code), .op_imm(op_imm), .stk_din(stk_din),
        .stk_push(stk_push), .stk_pop(stk_pop), .stk_tos(stk_tos),
        .stk_res(stk_res), .done(done), .result(result), .err(err)
    );

    always #5 clk = ~clk;

    // Operand stack: registered read data, pointer wraps, never reset.
    logic [7:0] mem [32];
    logic [4:0] sp = '0;
    initial stk_res = '0;
    always @(posedge clk) begin
        if (stk_push) begin
            mem[sp] <= stk_din;
            sp      <= sp + 5'd1;
        end else if (stk_pop) begin
            stk_res <= mem[sp - 5'd1];
            sp      <= sp - 5'd1;
        end else if (stk_tos) begin
            stk_res <= mem[sp - 5'd1];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_ready();
        for (int w = 0; w < 20 && !op_ready; w++) @(negedge clk);
        if (!op_ready) check("ready_timeout", 0, 1);
    endtask

    // Issue one op from a negedge and observe it up to (and including) its done cycle.
    task automatic run(input string tag, input logic [2:0] code, input logic [7:0] imm,
                       input int exp_lat, input logic [7:0] exp_res, input int exp_push,
                       input int exp_pop, input int exp_tos, input int exp_err);
        int lat = 0, np = 0, npop = 0, ntos = 0, nerr = 0, nmulti = 0;
        logic [7:0] res = '0;
        wait_ready();
        op_valid = 1'b1;
        op_code  = code;
        op_imm   = imm;
        @(posedge clk);
        #1 op_valid = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            np   += int'(stk_push);
            npop += int'(stk_pop);
            ntos += int'(stk_tos);
            nerr += int'(err);
            if (int'(stk_push) + int'(stk_pop) + int'(stk_tos) > 1) nmulti++;
            if (done) begin
                lat = n;
                res = result;
                break;
            end
        end
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_res"}, {24'd0, res}, {24'd0, exp_res});
        check({tag, "_push"}, np, exp_push);
        check({tag, "_pop"}, npop, exp_pop);
        check({tag, "_tos"}, ntos, exp_tos);
        check({tag, "_err"}, nerr, exp_err);
        check({tag, "_onehot"}, nmulti, 0);
    endtask

    initial begin
        int lat, np, npop, nd, ns;
        logic [7:0] res;
        rst = 1'b1; op_valid = 1'b0; op_code = NOP; op_imm = '0;
        repeat (3) @(negedge clk);
        check("rst_ready", op_ready, 1);
        check("rst_strobes", {stk_push, stk_pop, stk_tos}, 0);
        check("rst_done_err", {done, err}, 0);
        check("rst_result", result, 0);
        check("rst_din", stk_din, 0);
        rst = 1'b0;
        @(negedge clk);

`ifdef STK_DEPTH_CHECK_EN
        run("rej_add", ADD, 8'h00, 1, 8'h00, 0, 0, 0, 1);
`endif
        run("nop",   NOP,  8'h00, 1, 8'h00, 0, 0, 0, 0);
        run("push5", PUSH, 8'h05, 2, 8'h05, 1, 0, 0, 0);
        run("push3", PUSH, 8'h03, 2, 8'h03, 1, 0, 0, 0);
        run("sub",   SUB,  8'h00, 6, 8'h02, 1, 2, 0, 0);
        run("tos2",  TOS,  8'h00, 4, 8'h02, 0, 0, 1, 0);
        run("push1", PUSH, 8'h01, 2, 8'h01, 1, 0, 0, 0);
        run("pushf", PUSH, 8'hFF, 2, 8'hFF, 1, 0, 0, 0);
        run("add",   ADD,  8'h00, 6, 8'h00, 1, 2, 0, 0);
        run("push0f", PUSH, 8'h0F, 2, 8'h0F, 1, 0, 0, 0);
        run("not",   NOT,  8'h00, 5, 8'hF0, 1, 1, 0, 0);
        run("tosf0", TOS,  8'h00, 4, 8'hF0, 0, 0, 1, 0);
        run("pushaa", PUSH, 8'hAA, 2, 8'hAA, 1, 0, 0, 0);
        run("tosaa", TOS,  8'h00, 4, 8'hAA, 0, 0, 1, 0);
        run("popaa", POP,  8'h00, 4, 8'hAA, 0, 1, 0, 0);
        run("and",   AND,  8'h00, 6, 8'h00, 1, 2, 0, 0);
        run("push33", PUSH, 8'h33, 2, 8'h33, 1, 0, 0, 0);
        run("push0f2", PUSH, 8'h0F, 2, 8'h0F, 1, 0, 0, 0);

        // Stack now [2, 0, 33, 0F]; ADD held on op_valid while op_code churns.
        wait_ready();
        op_valid = 1'b1; op_code = ADD; op_imm = 8'h00;
        @(posedge clk);
        lat = 0; np = 0; npop = 0; res = '0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            np   += int'(stk_push);
            npop += int'(stk_pop);
            if (done) begin
                lat = n;
                res = result;
                break;
            end
            check("busy_ready", op_ready, 0);
            op_code = (n % 2 == 1) ? PUSH : NOP;
            op_imm  = 8'(n);
        end
        check("hold_lat", lat, 6);
        check("hold_res", res, 8'h42);
        check("hold_push", np, 1);
        check("hold_pop", npop, 2);
        op_code = TOS;
        @(negedge clk);
        check("after_done_ready", op_ready, 1);
        @(posedge clk);
        #1 op_valid = 1'b0;
        lat = 0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (done) begin
                lat = n;
                res = result;
                break;
            end
        end
        check("b2b_tos_lat", lat, 4);
        check("b2b_tos_res", res, 8'h42);

        // Stack [2, 0, 42]; abort an ADD during POP2.
        wait_ready();
        op_valid = 1'b1; op_code = ADD;
        @(posedge clk);
        #1 op_valid = 1'b0;
        @(negedge clk);
        check("abort_pop1", stk_pop, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_ready", op_ready, 1);
        check("abort_strobes", {stk_push, stk_pop, stk_tos}, 0);
        check("abort_result", result, 0);
        rst = 1'b0;
        nd = 0; ns = 0;
        repeat (8) begin
            @(negedge clk);
            nd += int'(done);
            ns += int'(stk_push) + int'(stk_pop) + int'(stk_tos);
        end
        check("abort_no_done", nd, 0);
        check("abort_no_strobe", ns, 0);

        // After the abort the stack holds [2]; TOS still sees it.
`ifdef STK_DEPTH_CHECK_EN
        run("abort_tos_rej", TOS, 8'h00, 1, 8'h00, 0, 0, 0, 1);
        for (int i = 1; i <= 32; i++) run("fill", PUSH, 8'(i), 2, 8'(i), 1, 0, 0, 0);
        run("overflow", PUSH, 8'hEE, 1, 8'h20, 0, 0, 0, 1);
        run("full_tos", TOS, 8'h00, 4, 8'h20, 0, 0, 1, 0);
`else
        run("abort_tos", TOS, 8'h00, 4, 8'h02, 0, 0, 1, 0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule

// File: doc/stack_op_sequencer.md
Name: stack_op_sequencer

Overview:
- Control stage directly upstream of the 8-bit, 32-entry operand stack in the stack-machine datapath.
- Accepts one stack-machine operation per handshake and issues the stack's push/pop/tos strobes in sequence.
- Captures the stack's registered read data, evaluates the operation, and pushes the result back.
- Reports completion and the result to the instruction controller.

Parameters:
WIDTH, 8, operand/stack data width
DEPTH, 32, stack entries (used only by the optional depth check)
DW, 6, depth counter width (must hold 0..DEPTH)

Ports:
clk  input  1  clock, all state changes on rising edge
rst  input  1  synchronous, active-high reset
op_valid  input  1  operation request
op_ready  output  1  high only in IDLE; op accepted when op_valid && op_ready at the clock edge
op_code  input  3  000 NOP, 001 PUSH, 010 POP, 011 ADD, 100 SUB, 101 AND, 110 NOT, 111 TOS
op_imm  input  WIDTH  immediate for PUSH
stk_din  output  WIDTH  data to stack dataIn
stk_push  output  1  stack push strobe
stk_pop  output  1  stack pop strobe
stk_tos  output  1  stack top-read strobe
stk_res  input  WIDTH  stack resStk; valid the cycle after a pop/tos strobe
done  output  1  one-cycle completion pulse
result  output  WIDTH  op result, held until the next done
err  output  1  one-cycle error pulse (optional feature only; tied 0 otherwise)

Behaviour:
- Reset: state IDLE. op_ready=1; stk_push, stk_pop, stk_tos, done and err are 0. result=0, stk_din=0. Internal T and N registers are 0.
- Reset takes priority in any state. Aborting mid-op leaves the stack's own pointer as-is, and no strobe is issued in the reset cycle or the cycle after it.
- Strobes are registered, one-hot among push/pop/tos, and each is high for exactly one cycle.
- Op, op_code and op_imm are latched at acceptance. Inputs are ignored while not in IDLE.
- States: IDLE, POP1, POP2, CAP2, EXEC, PUSH, DONE.
- Transitions from IDLE on acceptance:
  - NOP -> DONE.
  - PUSH -> PUSH, with stk_din=op_imm.
  - POP, NOT -> POP1.
  - TOS -> POP1, which issues stk_tos instead of stk_pop.
  - ADD, SUB, AND -> POP1.
- POP1: assert stk_pop (or stk_tos for TOS). The next state is POP2 for binary ops and CAP2 for unary ops.
- POP2: T <= stk_res (the top), and assert stk_pop. Next: CAP2.
- CAP2:
  - For binary ops: N <= stk_res.
  - For unary ops and TOS: T <= stk_res.
  - Next: EXEC.
- EXEC computes R, with all arithmetic modulo 2^WIDTH and no carry/borrow output:
  - ADD: R = N+T.
  - SUB: R = N-T.
  - AND: R = N&T.
  - NOT: R = ~T.
  - POP, TOS: R = T.
  - Next: PUSH for ADD/SUB/AND/NOT; DONE for POP/TOS.
- PUSH: assert stk_push with stk_din = R (or op_imm for PUSH). Next: DONE.
- DONE: done=1, result updated to R (to op_imm for PUSH; unchanged for NOP). Next: IDLE, with op_ready high again in the following cycle.
- Latencies from the acceptance edge to the done cycle:
  - NOP: 1.
  - PUSH: 2.
  - POP and TOS: 4.
  - NOT: 5.
  - Binary ops: 6.
- Back-to-back ops: the next op can be accepted in the cycle after done.
- Without the optional feature, underflow and overflow are not detected and the stack pointer wraps inside the stack.

Optional Feature:
- Macro: STK_DEPTH_CHECK_EN.
- When defined, the block keeps a DW-bit depth counter, reset to 0, tracking its own strobes: +1 per push, -1 per pop, no change for tos.
- At acceptance, an op is rejected when it would:
  - underflow: POP, TOS or NOT with depth 0, or a binary op with depth < 2;
  - overflow: PUSH with depth == DEPTH.
- On rejection:
  - the block goes IDLE -> DONE with no stack strobes;
  - done and err pulse together;
  - result is unchanged.
- When undefined: no counter, and err is tied 0.

Test Plan:
- Reset mid-op: rst during POP2 of an ADD -> next cycle IDLE, op_ready=1, all strobes 0, done never pulses for that op.
- PUSH 0x05, PUSH 0x03, SUB -> one push strobe per PUSH, two pops then one push for SUB; result=0x02, done 6 cycles after SUB accept; following TOS result=0x02.
- PUSH 0x01, PUSH 0xFF, ADD -> result=0x00 (wrap); PUSH 0x0F, NOT -> result=0xF0, stack top 0xF0.
- PUSH 0xAA, TOS, POP -> TOS result=0xAA with no pop strobe; POP result=0xAA with one pop strobe, zero push strobes.
- op_valid held high with changing op_code during a binary op -> op_ready low and inputs ignored; next op accepted in the cycle after done.
- With STK_DEPTH_CHECK_EN:
  - ADD at reset -> err and done on the 1st cycle after accept, no strobes.
  - 32 PUSHes then a 33rd -> the 33rd is rejected with err.
